// File: rtl/spe_omem_port_if.sv
// Bundle of the SPE core, router and status signals seen by one spe_omem_port.
// The slave modport is the port block itself; master is the surrounding core/router.
interface spe_omem_port_if #(
  parameter int SUM_WIDTH = 13,
  parameter int CNT_WIDTH = 8
);
  logic                 wr_valid;
  logic                 wr_ready;
  logic [SUM_WIDTH-1:0] wr_potential;
  logic                 wr_spike;
  logic                 rq_valid;
  logic                 rq_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [SUM_WIDTH-1:0] res_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [32:0]          tx_packet;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [32:0]          rx_packet;
  logic [1:0]           ts;
  logic                 ts_done;
  logic [CNT_WIDTH-1:0] wr_count;
  logic                 err_unexp;

  modport slave (
    input  wr_valid, wr_potential, wr_spike, rq_valid, res_ready,
           tx_ready, rx_valid, rx_packet,
    output wr_ready, rq_ready, res_valid, res_data, tx_valid, tx_packet,
           rx_ready, ts, ts_done, wr_count, err_unexp
  );

  modport master (
    output wr_valid, wr_potential, wr_spike, rq_valid, res_ready,
           tx_ready, rx_valid, rx_packet,
    input  wr_ready, rq_ready, res_valid, res_data, tx_valid, tx_packet,
           rx_ready, ts, ts_done, wr_count, err_unexp
  );
endinterface

// File: rtl/spe_omem_port.sv
// SPE-side endpoint of the SPE<->output-memory packet protocol: packs stores,
// issues residue requests, returns residues and tracks timestep-done broadcasts.
module spe_omem_port #(
  parameter int SPE_ID    = 0,
  parameter int OMEM_ID   = 11,
  parameter int SUM_WIDTH = 13,
  parameter int NUM_TS    = 2,
  parameter int CNT_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  spe_omem_port_if.slave     bus
);

  localparam logic [3:0] DEST_ADDR   = 4'(OMEM_ID);
  localparam logic [3:0] OP_STORE    = 4'(2 * SPE_ID);
  localparam logic [3:0] OP_REQUEST  = 4'(2 * SPE_ID + 1);
  localparam logic [3:0] OP_RESIDUE  = 4'd0;
  localparam logic [3:0] OP_TS_DONE  = 4'd15;
  localparam logic [1:0] TS_MAX      = 2'(NUM_TS);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    SEND_WR,
    SEND_RQ,
    WAIT_RES,
    DELIVER
  } state_t;

  state_t               state;
  logic                 tx_valid_q;
  logic [32:0]          tx_packet_q;
  logic                 res_valid_q;
  logic [SUM_WIDTH-1:0] res_data_q;
  logic [1:0]           ts_q;
  logic                 ts_done_q;
  logic [CNT_WIDTH-1:0] wr_count_q;
  logic                 err_unexp_q;

  logic                 wr_fire;
  logic                 rq_fire;
  logic                 rx_fire;
  logic [3:0]           rx_opcode;
  logic                 store_done;
  logic                 ts_event;
  logic                 unused_rx_bits;

  assign bus.wr_ready  = (state == IDLE);
  assign bus.rq_ready  = (state == IDLE) && !bus.wr_valid;
  assign bus.rx_ready  = (state != DELIVER);

  assign wr_fire    = bus.wr_valid && bus.wr_ready;
  assign rq_fire    = bus.rq_valid && bus.rq_ready;
  assign rx_fire    = bus.rx_valid && bus.rx_ready;
  assign rx_opcode  = bus.rx_packet[28:25];
  assign store_done = (state == SEND_WR) && bus.tx_ready;
  assign ts_event   = rx_fire && (rx_opcode == OP_TS_DONE);

  // Destination address and the upper residue data bits carry nothing for this block.
  assign unused_rx_bits = ^{bus.rx_packet[32:29], bus.rx_packet[24:SUM_WIDTH]};

  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_packet = tx_packet_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.ts        = ts_q;
  assign bus.ts_done   = ts_done_q;
  assign bus.wr_count  = wr_count_q;
  assign bus.err_unexp = err_unexp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tx_valid_q  <= 1'b0;
      tx_packet_q <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_fire) begin
            tx_valid_q  <= 1'b1;
            tx_packet_q <= {DEST_ADDR, OP_STORE, 24'(bus.wr_potential), bus.wr_spike};
            state       <= SEND_WR;
          end else if (rq_fire) begin
            tx_valid_q  <= 1'b1;
            tx_packet_q <= {DEST_ADDR, OP_REQUEST, 25'd0};
            state       <= SEND_RQ;
          end
        end
        SEND_WR: begin
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            state      <= IDLE;
          end
        end
        SEND_RQ: begin
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            state      <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (rx_fire && (rx_opcode == OP_RESIDUE)) begin
            res_data_q  <= bus.rx_packet[SUM_WIDTH-1:0];
            res_valid_q <= 1'b1;
            state       <= DELIVER;
          end
        end
        DELIVER: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A timestep-done clears the counter first, so a store finishing on the same edge counts as 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q        <= 2'd1;
      ts_done_q   <= 1'b0;
      wr_count_q  <= '0;
      err_unexp_q <= 1'b0;
    end else begin
      ts_done_q <= ts_event;
      if (ts_event) begin
        if (ts_q < TS_MAX) begin
          ts_q <= ts_q + 2'd1;
        end
        wr_count_q <= store_done ? CNT_ONE : '0;
      end else if (store_done && (wr_count_q != CNT_MAX)) begin
        wr_count_q <= wr_count_q + CNT_ONE;
      end
      if (rx_fire && (rx_opcode == OP_RESIDUE) && (state != WAIT_RES)) begin
        err_unexp_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spe_omem_port.sv
// Directed self-checking bench for spe_omem_port (SPE_ID=2, OMEM_ID=11, NUM_TS=2).
module tb_spe_omem_port;

  localparam int SUM_WIDTH = 13;
  localparam int CNT_WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   assertCount = 0;
  int   failCount   = 0;

  spe_omem_port_if #(.SUM_WIDTH(SUM_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  spe_omem_port #(
    .SPE_ID(2), .OMEM_ID(11), .SUM_WIDTH(SUM_WIDTH), .NUM_TS(2), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic wv, input logic [SUM_WIDTH-1:0] pot, input logic sp,
                               input logic rqv, input logic resr, input logic txr,
                               input logic rxv, input logic [32:0] rxp);
    bus.wr_valid     = wv;
    bus.wr_potential = pot;
    bus.wr_spike     = sp;
    bus.rq_valid     = rqv;
    bus.res_ready    = resr;
    bus.tx_ready     = txr;
    bus.rx_valid     = rxv;
    bus.rx_packet    = rxp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] rxPkt(input logic [3:0] op, input logic [24:0] data);
    return {4'd0, op, data};
  endfunction

  initial begin
    rst = 1'b1;
    applyStimulus(0, '0, 0, 0, 0, 0, 0, '0);
    tick();
    tick();
    checkOutput("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    checkOutput("rst_tx_packet", 64'(bus.tx_packet), 64'd0);
    checkOutput("rst_res_valid", 64'(bus.res_valid), 64'd0);
    checkOutput("rst_res_data", 64'(bus.res_data), 64'd0);
    checkOutput("rst_ts", 64'(bus.ts), 64'd1);
    checkOutput("rst_ts_done", 64'(bus.ts_done), 64'd0);
    checkOutput("rst_wr_count", 64'(bus.wr_count), 64'd0);
    checkOutput("rst_err", 64'(bus.err_unexp), 64'd0);
    checkOutput("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
    checkOutput("rst_rx_ready", 64'(bus.rx_ready), 64'd1);
    rst = 1'b0;
    tick();

    // Single store: {B, 4, 100, 1}
    applyStimulus(1, 13'd100, 1, 0, 0, 1, 0, '0);
    tick();
    applyStimulus(0, '0, 0, 0, 0, 1, 0, '0);
    checkOutput("st_tx_valid", 64'(bus.tx_valid), 64'd1);
    checkOutput("st_tx_packet", 64'(bus.tx_packet), 64'h1_6800_00C9);
    checkOutput("st_wr_ready_busy", 64'(bus.wr_ready), 64'd0);
    tick();
    checkOutput("st_tx_done", 64'(bus.tx_valid), 64'd0);
    checkOutput("st_wr_count", 64'(bus.wr_count), 64'd1);
    checkOutput("st_idle", 64'(bus.wr_ready), 64'd1);

    // Back-to-back stores held valid: one every 2 cycles
    applyStimulus(1, 13'd5, 0, 0, 0, 1, 0, '0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) applyStimulus(0, '0, 0, 0, 0, 1, 0, '0);
      checkOutput($sformatf("b2b_tx_valid_%0d", i), 64'(bus.tx_valid), (i % 2 == 0) ? 64'd1 : 64'd0);
      if (i == 0) checkOutput("b2b_packet", 64'(bus.tx_packet), 64'h1_6800_000A);
    end
    checkOutput("b2b_wr_count", 64'(bus.wr_count), 64'd3);

    // Store and request together: store first
    applyStimulus(1, 13'd7, 0, 1, 0, 1, 0, '0);
    #1;
    checkOutput("both_rq_ready", 64'(bus.rq_ready), 64'd0);
    tick();
    bus.wr_valid = 1'b0;
    checkOutput("both_store_pkt", 64'(bus.tx_packet), 64'h1_6800_000E);
    tick();
    checkOutput("both_wr_count", 64'(bus.wr_count), 64'd4);
    checkOutput("both_rq_ready_idle", 64'(bus.rq_ready), 64'd1);
    tick();
    bus.rq_valid = 1'b0;
    checkOutput("rq_tx_valid", 64'(bus.tx_valid), 64'd1);
    checkOutput("rq_tx_packet", 64'(bus.tx_packet), 64'h1_6A00_0000);
    tick();
    checkOutput("rq_wait_tx_valid", 64'(bus.tx_valid), 64'd0);
    checkOutput("rq_wait_wr_ready", 64'(bus.wr_ready), 64'd0);

    // Residue return and held delivery
    applyStimulus(0, '0, 0, 0, 0, 1, 1, rxPkt(4'd0, 25'd1234));
    tick();
    bus.rx_valid = 1'b0;
    checkOutput("res_valid", 64'(bus.res_valid), 64'd1);
    checkOutput("res_data", 64'(bus.res_data), 64'd1234);
    checkOutput("res_no_err", 64'(bus.err_unexp), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("res_hold_valid_%0d", i), 64'(bus.res_valid), 64'd1);
      checkOutput($sformatf("res_hold_rx_ready_%0d", i), 64'(bus.rx_ready), 64'd0);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    checkOutput("res_consumed", 64'(bus.res_valid), 64'd0);
    checkOutput("res_back_idle", 64'(bus.wr_ready), 64'd1);

    // Timestep-done broadcasts
    applyStimulus(0, '0, 0, 0, 0, 1, 1, rxPkt(4'd15, 25'd0));
    tick();
    bus.rx_valid = 1'b0;
    checkOutput("ts1_done", 64'(bus.ts_done), 64'd1);
    checkOutput("ts1_ts", 64'(bus.ts), 64'd2);
    checkOutput("ts1_wr_count", 64'(bus.wr_count), 64'd0);
    tick();
    checkOutput("ts1_pulse_end", 64'(bus.ts_done), 64'd0);
    applyStimulus(1, 13'd3, 1, 0, 0, 0, 0, '0);
    tick();
    applyStimulus(0, '0, 0, 0, 0, 1, 1, rxPkt(4'd15, 25'd0));
    tick();
    bus.rx_valid = 1'b0;
    checkOutput("ts2_same_edge_count", 64'(bus.wr_count), 64'd1);
    checkOutput("ts2_ts_sat", 64'(bus.ts), 64'd2);
    checkOutput("ts2_done", 64'(bus.ts_done), 64'd1);
    tick();
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    checkOutput("ts3_done", 64'(bus.ts_done), 64'd1);
    checkOutput("ts3_wr_count", 64'(bus.wr_count), 64'd0);
    checkOutput("ts3_ts", 64'(bus.ts), 64'd2);

    // Unexpected residue in IDLE, then an unrelated opcode
    applyStimulus(0, '0, 0, 0, 0, 1, 1, rxPkt(4'd0, 25'd99));
    tick();
    bus.rx_packet = rxPkt(4'd3, 25'd7);
    checkOutput("unexp_err", 64'(bus.err_unexp), 64'd1);
    checkOutput("unexp_idle", 64'(bus.wr_ready), 64'd1);
    checkOutput("unexp_no_res", 64'(bus.res_valid), 64'd0);
    tick();
    bus.rx_valid = 1'b0;
    checkOutput("other_op_err_sticky", 64'(bus.err_unexp), 64'd1);
    checkOutput("other_op_no_tx", 64'(bus.tx_valid), 64'd0);

    // Stalled store then async reset mid-stall
    applyStimulus(1, 13'd8191, 1, 0, 0, 0, 0, '0);
    tick();
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("stall_pkt_%0d", i), 64'(bus.tx_packet), 64'h1_6800_3FFF);
      checkOutput($sformatf("stall_valid_%0d", i), 64'(bus.tx_valid), 64'd1);
    end
    rst = 1'b1;
    #1;
    checkOutput("async_rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    checkOutput("async_rst_tx_packet", 64'(bus.tx_packet), 64'd0);
    tick();
    rst = 1'b0;
    bus.tx_ready = 1'b1;
    tick();
    checkOutput("post_rst_wr_count", 64'(bus.wr_count), 64'd0);
    checkOutput("post_rst_ts", 64'(bus.ts), 64'd1);
    checkOutput("post_rst_err", 64'(bus.err_unexp), 64'd0);
    checkOutput("post_rst_tx_valid", 64'(bus.tx_valid), 64'd0);

    // 260 stores saturate the counter at 255
    applyStimulus(1, 13'd1, 0, 0, 0, 1, 0, '0);
    for (int i = 0; i < 520; i++) tick();
    bus.wr_valid = 1'b0;
    tick();
    checkOutput("sat_wr_count", 64'(bus.wr_count), 64'd255);
    checkOutput("sat_idle", 64'(bus.wr_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
